regfile_sb: RTL

- Parametrised successor to the toy core's general-purpose register file.
- Storage width, depth and read-port count are parameters.
- Adds write-to-read bypass and a per-register pending-write scoreboard, so the ID stage gets a single STALL signal for read-after-write hazards that forwarding cannot cover (load-use, multi-cycle results).
- Sits in ID: read ports feed the DE register; writeback drives the write port; the issue/kill ports are driven by the ID/EX control logic.

---
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_sb.sv | 82 ++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bundle between ID/EX control (master) and regfile_sb (slave):
// writeback port, read ports and scoreboard issue/kill channel.
interface regfile_sb_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRP = 2
);
  // WEN, ISS and KILL are single-cycle qualifiers sampled on the rising edge;
  // there is no backpressure, every qualified event is taken in its own cycle.
  logic              WEN;
  logic [AW-1:0]     WA;
  logic [DW-1:0]     DI;
  logic [NRP*AW-1:0] RA;
  logic [NRP-1:0]    RUSE;
  logic [NRP*DW-1:0] DOUT;
  logic              ISS;
  logic [AW-1:0]     ISS_WA;
  logic              KILL;
  logic [AW-1:0]     KILL_WA;
  logic [NRP-1:0]    BUSY;
  logic              STALL;
  logic              OVF;

  modport master (
    output WEN, WA, DI, RA, RUSE, ISS, ISS_WA, KILL, KILL_WA,
    input  DOUT, BUSY, STALL, OVF
  );

  modport slave (
    input  WEN, WA, DI, RA, RUSE, ISS, ISS_WA, KILL, KILL_WA,
    output DOUT, BUSY, STALL, OVF
  );
endinterface

// File: rtl/regfile_sb.sv
// General-purpose register file with write-to-read bypass and a per-register
// pending-write scoreboard that produces a single read-after-write STALL.
module regfile_sb #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NRP     = 2,
  parameter int CW      = 2,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic          CLK,
  input  logic          RSTN,
  regfile_sb_if.slave   rf
);
  localparam int ENTRY = 1 << AW;
  localparam int CMAX  = (1 << CW) - 1;

  logic [DW-1:0]  mem_q [ENTRY];
  logic [CW-1:0]  cnt_q [ENTRY];
  logic [CW-1:0]  cnt_d [ENTRY];
  logic           ovf_q, ovf_d;
  logic           wr_ok;
  logic [NRP-1:0] busy;
  int             nxt_cnt;

  assign wr_ok = rf.WEN && !(R0_ZERO && (rf.WA == '0));

  // Issue, writeback and kill may all hit one register in the same cycle;
  // their deltas are summed, then clamped with the sticky error flag.
  always_comb begin
    ovf_d   = ovf_q;
    nxt_cnt = 0;
    for (int r = 0; r < ENTRY; r++) begin
      nxt_cnt = int'(cnt_q[r])
              + int'(rf.ISS  && (rf.ISS_WA  == AW'(r)))
              - int'(rf.WEN  && (rf.WA      == AW'(r)))
              - int'(rf.KILL && (rf.KILL_WA == AW'(r)));
      if (R0_ZERO && (r == 0)) begin
        cnt_d[r] = '0;
      end else if (nxt_cnt > CMAX) begin
        cnt_d[r] = CW'(CMAX);
        ovf_d    = 1'b1;
      end else if (nxt_cnt < 0) begin
        cnt_d[r] = '0;
        ovf_d    = 1'b1;
      end else begin
        cnt_d[r] = nxt_cnt[CW-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int r = 0; r < ENTRY; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      if (wr_ok) mem_q[rf.WA] <= rf.DI;
      for (int r = 0; r < ENTRY; r++) cnt_q[r] <= cnt_d[r];
      ovf_q <= ovf_d;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          zero;
    assign ra   = rf.RA[i*AW +: AW];
    assign hit  = rf.WEN && (rf.WA == ra);
    assign zero = R0_ZERO && (ra == '0);
    // Outputs are forced low during reset so a bypassed DI cannot leak out.
    assign rf.DOUT[i*DW +: DW] = (!RSTN || zero) ? '0
                               : (hit ? rf.DI : mem_q[ra]);
    // A write landing this cycle retires one pending write for the reader.
    assign busy[i] = RSTN && !zero && (cnt_q[ra] != CW'(hit));
  end

  assign rf.BUSY  = busy;
  assign rf.STALL = |(busy & rf.RUSE);
  assign rf.OVF   = ovf_q;
endmodule
